// File: rtl/b16_dbg_pkg.sv
// Shared encodings for the b16 multi-breakpoint debug unit: local register
// offsets, FSM state codes, halt-cause codes and CTRL write bit positions.
package b16_dbg_pkg;

    localparam logic [2:0] R_CTRL    = 3'd0;
    localparam logic [2:0] R_BPSEL   = 3'd1;
    localparam logic [2:0] R_BPADDR  = 3'd2;
    localparam logic [2:0] R_BPEN    = 3'd3;
    localparam logic [2:0] R_STEPCNT = 3'd4;
    localparam logic [2:0] R_HITIDX  = 3'd5;
    localparam logic [2:0] R_WATCH   = 3'd6;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } dbg_state_t;

    typedef enum logic [1:0] {
        C_NONE = 2'd0,
        C_BP   = 2'd1,
        C_STEP = 2'd2,
        C_HOST = 2'd3
    } dbg_cause_t;

    localparam int CW_HALT = 0;
    localparam int CW_RUN  = 1;
    localparam int CW_STEP = 2;

endpackage

// File: rtl/b16_bp_cmp.sv
// One breakpoint slot: holds address, enable and watch bits and flags an
// address match on a CPU fetch (or on a CPU write when the watch bit is set).
module b16_bp_cmp #(
    parameter int L = 16
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         addr_we,
    input  logic         en_we,
    input  logic         watch_we,
    input  logic [L-1:0] addr_d,
    input  logic         en_d,
    input  logic         watch_d,
    input  logic [L-1:0] cpu_addr,
    input  logic         cpu_rd,
    input  logic         cpu_wr_any,
    output logic [L-1:0] bpaddr,
    output logic         en,
    output logic         watch,
    output logic         match
);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bpaddr <= '1;
            en     <= 1'b0;
            watch  <= 1'b0;
        end else begin
            if (addr_we)  bpaddr <= addr_d;
            if (en_we)    en     <= en_d;
            if (watch_we) watch  <= watch_d;
        end
    end

    assign match = en && (watch ? cpu_wr_any : cpu_rd) && (cpu_addr == bpaddr);

endmodule

// File: rtl/b16_dbg_unit.sv
// b16 debug controller: host window decode, run/halt/step FSM, NBP breakpoints.
// Define B16_DBG_WATCH_EN to enable the per-breakpoint write-watch mask (register 6).
module b16_dbg_unit
    import b16_dbg_pkg::*;
#(
    parameter int             L       = 16,
    parameter int             NBP     = 4,
    parameter logic [L-6:0]   DBGADDR = 11'h7FF,
    parameter int             STEPW   = 8
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         ce,
    input  logic [L-1:1] addr,
    input  logic [L-1:0] data,
    input  logic         r,
    input  logic [1:0]   w,
    output logic [L-1:0] rdata,
    input  logic [L-1:0] cpu_addr,
    input  logic         cpu_rd,
    input  logic [1:0]   cpu_wr,
    output logic         drun,
    output logic         dr,
    output logic         dw,
    output logic [2:0]   daddr,
    output logic         halted
);

    logic                    dsel, loc, loc_wr, ctrl_wr, cnt_wr, en_we, watch_we, skip, skip_nxt;
    logic [2:0]              off, hitidx, hitidx_nxt, hit_idx;
    logic [L-1:0]            bpsel, ctrl_rd;
    logic [STEPW-1:0]        stepcnt, cnt_nxt;
    logic [NBP-1:0][L-1:0]   bp_addr;
    logic [NBP-1:0]          en_q, watch_q, match, hit_vec;
    logic                    hit;
    dbg_state_t              state, state_nxt;
    dbg_cause_t              cause, cause_nxt;

    assign dsel    = addr[L-1:5] == DBGADDR;
    assign loc     = dsel && addr[4];
    assign off     = addr[3:1];
    assign dr      = dsel && !addr[4] && r;
    assign dw      = dsel && !addr[4] && (|w);
    assign daddr   = addr[3:1];
    assign loc_wr  = loc && (|w);
    assign ctrl_wr = loc_wr && (off == R_CTRL);
    assign cnt_wr  = loc_wr && (off == R_STEPCNT);
    assign en_we   = loc_wr && (off == R_BPEN);

`ifdef B16_DBG_WATCH_EN
    assign watch_we = loc_wr && (off == R_WATCH);
`else
    logic unused_watch;
    assign watch_we     = 1'b0;
    assign unused_watch = |watch_q;
`endif

    for (genvar i = 0; i < NBP; i++) begin : g_bp
        b16_bp_cmp #(.L(L)) u_cmp (
            .clk        (clk),
            .nreset     (nreset),
            .addr_we    (loc_wr && (off == R_BPADDR) && (bpsel == L'(i))),
            .en_we      (en_we),
            .watch_we   (watch_we),
            .addr_d     (data),
            .en_d       (data[i]),
            .watch_d    (data[i]),
            .cpu_addr   (cpu_addr),
            .cpu_rd     (cpu_rd),
            .cpu_wr_any (|cpu_wr),
            .bpaddr     (bp_addr[i]),
            .en         (en_q[i]),
            .watch      (watch_q[i]),
            .match      (match[i])
        );
    end

    // The first ce after leaving HALT is the re-fetch of the halting address.
    assign hit_vec = match & {NBP{ce && drun && !skip}};
    assign hit     = |hit_vec;

    always_comb begin
        hit_idx = '0;
        for (int i = NBP - 1; i >= 0; i--)
            if (hit_vec[i]) hit_idx = 3'(i);
    end

    always_comb begin
        state_nxt  = state;
        cause_nxt  = cause;
        skip_nxt   = skip;
        cnt_nxt    = stepcnt;
        hitidx_nxt = hitidx;
        if (skip && ce && drun) skip_nxt = 1'b0;
        if (ctrl_wr && data[CW_HALT]) begin
            if (state != ST_HALT) begin
                state_nxt = ST_HALT;
                cause_nxt = C_HOST;
            end
        end else if (ctrl_wr && data[CW_RUN] && state == ST_HALT) begin
            if (!data[CW_STEP]) begin
                state_nxt = ST_RUN;
                skip_nxt  = 1'b1;
            end else if (stepcnt != '0) begin
                state_nxt = ST_STEP;
                skip_nxt  = 1'b1;
            end else begin
                cause_nxt = C_STEP;
            end
        end else if (hit) begin
            state_nxt  = ST_HALT;
            cause_nxt  = C_BP;
            hitidx_nxt = hit_idx;
        end else if (state == ST_STEP && ce) begin
            cnt_nxt = stepcnt - STEPW'(1);
            if (stepcnt <= STEPW'(1)) begin
                cnt_nxt   = '0;
                state_nxt = ST_HALT;
                cause_nxt = C_STEP;
            end
        end
        if (cnt_wr) cnt_nxt = data[STEPW-1:0];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= ST_RUN;
            cause   <= C_NONE;
            skip    <= 1'b0;
            stepcnt <= '0;
            hitidx  <= '0;
            bpsel   <= '0;
            drun    <= 1'b1;
            halted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cause   <= cause_nxt;
            skip    <= skip_nxt;
            stepcnt <= cnt_nxt;
            hitidx  <= hitidx_nxt;
            drun    <= state_nxt != ST_HALT;
            halted  <= state_nxt == ST_HALT;
            if (loc_wr && off == R_BPSEL) bpsel <= data;
        end
    end

    assign ctrl_rd = {drun, state, cause, {(L-6){1'b0}}, skip};

    always_comb begin
        rdata = '0;
        if (loc && r) begin
            case (off)
                R_CTRL:    rdata = ctrl_rd;
                R_BPSEL:   rdata = bpsel;
                R_BPADDR:  for (int i = 0; i < NBP; i++)
                               if (bpsel == L'(i)) rdata = bp_addr[i];
                R_BPEN:    rdata = L'(en_q);
                R_STEPCNT: rdata = L'(stepcnt);
                R_HITIDX:  rdata = L'(hitidx);
`ifdef B16_DBG_WATCH_EN
                R_WATCH:   rdata = L'(watch_q);
`endif
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_b16_dbg_unit.sv
// Directed self-checking bench for b16_dbg_unit (default NBP=4, L=16).
module tb_b16_dbg_unit;

    logic        clk = 1'b0, nreset = 1'b0, ce = 1'b0, r = 1'b0, cpu_rd = 1'b0;
    logic [15:1] addr = '0;
    logic [15:0] data = '0, rdata, cpu_addr = '0, v;
    logic [1:0]  w = '0, cpu_wr = '0;
    logic        drun, dr, dw, halted;
    logic [2:0]  daddr;
    int          errors = 0, checks = 0;

    b16_dbg_unit dut (
        .clk(clk), .nreset(nreset), .ce(ce), .addr(addr), .data(data), .r(r), .w(w),
        .rdata(rdata), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .drun(drun), .dr(dr), .dw(dw), .daddr(daddr), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:1] la(input logic [2:0] k);
        return {11'h7FF, 1'b1, k};
    endfunction

    task automatic host_wr(input logic [2:0] k, input logic [15:0] val);
        @(negedge clk);
        addr = la(k); data = val; w = 2'b11;
        @(negedge clk);
        w = 2'b00;
    endtask

    task automatic host_rd(input logic [2:0] k, output logic [15:0] val);
        @(negedge clk);
        addr = la(k); r = 1'b1;
        #1 val = rdata;
        r = 1'b0;
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic rd, input logic [1:0] wr);
        @(negedge clk);
        ce = 1'b1; cpu_addr = a; cpu_rd = rd; cpu_wr = wr;
        @(negedge clk);
        ce = 1'b0; cpu_rd = 1'b0; cpu_wr = 2'b00;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (drun !== 1'b1)   begin errors++; $display("FAIL reset_drun got %b want 1", drun); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        host_rd(3'd0, v);
        checks++; if (v !== 16'hA000) begin errors++; $display("FAIL reset_ctrl got %h want a000", v); end
        for (int i = 0; i < 4; i++) begin
            host_wr(3'd1, 16'(i));
            host_rd(3'd2, v);
            checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL reset_bpaddr%0d got %h want ffff", i, v); end
        end
        host_rd(3'd3, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_bpen got %h want 0000", v); end
    endtask

    task automatic test_bp_hit;
        host_wr(3'd1, 16'd2);
        host_wr(3'd2, 16'h0100);
        host_wr(3'd3, 16'h0004);
        cpu_cycle(16'h0100, 1'b0, 2'b11);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL write_no_halt got %b want 0", halted); end
        cpu_cycle(16'h0100, 1'b1, 2'b00);
        checks++; if (halted !== 1'b1 || drun !== 1'b0)
            begin errors++; $display("FAIL fetch_halt halted=%b drun=%b want 1 0", halted, drun); end
        host_rd(3'd0, v);
        checks++; if (v !== 16'h0800) begin errors++; $display("FAIL bp_cause got %h want 0800", v); end
        host_rd(3'd5, v);
        checks++; if (v !== 16'd2) begin errors++; $display("FAIL hitidx got %h want 0002", v); end
    endtask

    task automatic test_skip;
        host_wr(3'd0, 16'h0002);
        host_rd(3'd0, v);
        checks++; if (v !== 16'hA801) begin errors++; $display("FAIL resume_ctrl got %h want a801", v); end
        cpu_cycle(16'h0100, 1'b1, 2'b00);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL skip_refetch got %b want 0", halted); end
        cpu_cycle(16'h0100, 1'b1, 2'b00);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL second_fetch got %b want 1", halted); end
    endtask

    task automatic test_step;
        host_wr(3'd0, 16'h0006);
        host_rd(3'd0, v);
        checks++; if (v !== 16'h1000 || halted !== 1'b1)
            begin errors++; $display("FAIL step_zero ctrl=%h halted=%b want 1000 1", v, halted); end
        host_wr(3'd3, 16'h0000);
        host_wr(3'd4, 16'd3);
        host_wr(3'd0, 16'h0006);
        host_rd(3'd0, v);
        checks++; if (v !== 16'hD001) begin errors++; $display("FAIL step_ctrl got %h want d001", v); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (drun !== 1'b1) begin errors++; $display("FAIL step_drun%0d got %b want 1", k, drun); end
            cpu_cycle(16'h0000, 1'b0, 2'b00);
        end
        host_rd(3'd0, v);
        checks++; if (v !== 16'h1000 || halted !== 1'b1)
            begin errors++; $display("FAIL step_done ctrl=%h halted=%b want 1000 1", v, halted); end
        host_rd(3'd4, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL step_cnt got %h want 0000", v); end
        host_wr(3'd3, 16'h0004);
        host_wr(3'd4, 16'd5);
        host_wr(3'd0, 16'h0006);
        cpu_cycle(16'h0000, 1'b0, 2'b00);
        cpu_cycle(16'h0100, 1'b1, 2'b00);
        host_rd(3'd4, v);
        checks++; if (v !== 16'd4 || halted !== 1'b1)
            begin errors++; $display("FAIL step_bp cnt=%h halted=%b want 0004 1", v, halted); end
        host_rd(3'd0, v);
        checks++; if (v !== 16'h0800) begin errors++; $display("FAIL step_bp_cause got %h want 0800", v); end
    endtask

    task automatic test_host_race;
        host_wr(3'd0, 16'h0002);
        cpu_cycle(16'h0000, 1'b0, 2'b00);
        @(negedge clk);
        addr = la(3'd0); data = 16'h0001; w = 2'b11;
        ce = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h0100;
        @(negedge clk);
        w = 2'b00; ce = 1'b0; cpu_rd = 1'b0;
        host_rd(3'd0, v);
        checks++; if (v !== 16'h1800 || halted !== 1'b1)
            begin errors++; $display("FAIL race_cause ctrl=%h halted=%b want 1800 1", v, halted); end
    endtask

    task automatic test_window;
        @(negedge clk);
        addr = {11'h7FF, 1'b0, 3'd5}; data = 16'hFFFF; w = 2'b11;
        #1;
        checks++; if (dw !== 1'b1 || dr !== 1'b0 || daddr !== 3'd5)
            begin errors++; $display("FAIL win_wr dw=%b dr=%b daddr=%0d want 1 0 5", dw, dr, daddr); end
        @(negedge clk);
        w = 2'b00; addr = {11'h7FF, 1'b0, 3'd3}; r = 1'b1;
        #1;
        checks++; if (dr !== 1'b1 || dw !== 1'b0 || rdata !== 16'h0000)
            begin errors++; $display("FAIL win_rd dr=%b dw=%b rdata=%h want 1 0 0000", dr, dw, rdata); end
        r = 1'b0;
        host_rd(3'd4, v);
        checks++; if (v !== 16'd4) begin errors++; $display("FAIL win_cnt got %h want 0004", v); end
        host_rd(3'd0, v);
        checks++; if (v !== 16'h1800) begin errors++; $display("FAIL win_ctrl got %h want 1800", v); end
        @(negedge clk);
        addr = 15'h0005; w = 2'b11; r = 1'b1;
        #1;
        checks++; if (dw !== 1'b0 || dr !== 1'b0)
            begin errors++; $display("FAIL outside dw=%b dr=%b want 0 0", dw, dr); end
        @(negedge clk);
        w = 2'b00; r = 1'b0;
    endtask

    task automatic test_regs;
        host_wr(3'd1, 16'd5);
        host_wr(3'd2, 16'h1234);
        host_rd(3'd2, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL bpsel_oob got %h want 0000", v); end
        host_wr(3'd1, 16'd1);
        host_rd(3'd2, v);
        checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL bpsel1 got %h want ffff", v); end
        host_wr(3'd1, 16'd2);
        host_rd(3'd2, v);
        checks++; if (v !== 16'h0100) begin errors++; $display("FAIL bpsel2 got %h want 0100", v); end
        host_wr(3'd7, 16'hFFFF);
        host_rd(3'd7, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reg7 got %h want 0000", v); end
`ifndef B16_DBG_WATCH_EN
        host_wr(3'd6, 16'h000F);
        host_rd(3'd6, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reg6 got %h want 0000", v); end
`endif
    endtask

`ifdef B16_DBG_WATCH_EN
    task automatic test_watch;
        host_wr(3'd1, 16'd0);
        host_wr(3'd2, 16'h2000);
        host_wr(3'd6, 16'h0001);
        host_wr(3'd3, 16'h0001);
        host_wr(3'd0, 16'h0002);
        cpu_cycle(16'h0000, 1'b0, 2'b00);
        cpu_cycle(16'h2000, 1'b1, 2'b00);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL watch_fetch got %b want 0", halted); end
        cpu_cycle(16'h2000, 1'b0, 2'b01);
        host_rd(3'd0, v);
        checks++; if (v !== 16'h0800 || halted !== 1'b1)
            begin errors++; $display("FAIL watch_hit ctrl=%h halted=%b want 0800 1", v, halted); end
    endtask
`endif

    task automatic test_async_reset;
        @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || drun !== 1'b1)
            begin errors++; $display("FAIL async_rst halted=%b drun=%b want 0 1", halted, drun); end
        @(negedge clk);
        nreset = 1'b1;
        host_rd(3'd4, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL rst_cnt got %h want 0000", v); end
        host_rd(3'd3, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL rst_bpen got %h want 0000", v); end
        host_wr(3'd1, 16'd2);
        host_rd(3'd2, v);
        checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL rst_bpaddr got %h want ffff", v); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        test_reset;
        test_bp_hit;
        test_skip;
        test_step;
        test_host_race;
        test_window;
        test_regs;
`ifdef B16_DBG_WATCH_EN
        test_watch;
`endif
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
